// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared FSM state encoding and word geometry for the instruction-memory loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs an MSB-first byte stream into 32-bit words.
// word_ready_o pulses combinationally on the cycle the last byte of a word is accepted.
module imem_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (valid_i) begin
      shift_d = {shift_q[23:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_ready_o = valid_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a byte image into instruction memory while holding the CPU.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the err output.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic              err
`endif
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_now;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_word;
  logic              asm_clear, asm_valid, asm_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
  logic              err_q, err_d;
`endif

  // Address arithmetic truncates to ADDR_W, so loads wrap past the top of memory.
  assign addr_now = ADDR_W'(BASE_ADDR) + widx_q;

  imem_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .valid_i      (asm_valid),
    .byte_i       (in_byte),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    err_d     = err_q;
`endif
    asm_clear = 1'b0;
    asm_valid = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    done      = 1'b0;
    cpu_hold  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cpu_hold = 1'b0;
        if (start) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = '0;
          err_d = 1'b0;
`endif
          if (len != '0) begin
            len_d     = len;
            widx_d    = '0;
            asm_clear = 1'b1;
            state_d   = ST_RECV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RECV: begin
        in_ready  = 1'b1;
        asm_valid = in_valid;
`ifdef LOADER_CHECKSUM_EN
        if (in_valid) xor_d = xor_q ^ in_byte;
`endif
        if (asm_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_now;
        mem_wdata = asm_word;
        addr_d    = addr_now;
        wdata_d   = asm_word;
        widx_d    = widx_q + 1'b1;
        if (widx_d != len_q) begin
          state_d = ST_RECV;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          err_d   = (in_byte != xor_q);
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word/address model.
// Two instances share stimulus: BASE_ADDR=0 and BASE_ADDR=254; LOADER_CHECKSUM_EN selects the checksum build.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready, mem_we, cpu_hold, done;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        in_ready_b, mem_we_b, cpu_hold_b, done_b;
  logic [7:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic        err, err_b;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .err(err)
`endif
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_hold(cpu_hold_b), .done(done_b)
`ifdef LOADER_CHECKSUM_EN
    , .err(err_b)
`endif
  );

`ifndef LOADER_CHECKSUM_EN
  assign err   = 1'b0;
  assign err_b = 1'b0;
`endif

  always #5 clk = ~clk;

  int          cyc = 0;
  int          t0 = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rdy_cnt = 0;
  int          hold_bad = 0;
  bit          track = 1'b0;
  logic [7:0]  stim[$];
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  wab[$];
  logic [31:0] wdb[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end
    if (mem_we_b) begin wab.push_back(mem_addr_b); wdb.push_back(mem_wdata_b); end
    if (done) done_cnt++;
    if (in_ready) rdy_cnt++;
    if (track && !cpu_hold) hold_bad++;
  end

  // Reference model: word i is bytes 4i..4i+3 MSB-first, stored at (base+i) mod 256.
  function automatic logic [31:0] exp_word(input int i);
    return {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
  endfunction

  function automatic logic [7:0] exp_addr(input int base, input int i);
    return 8'((base + i) % 256);
  endfunction

  function automatic logic [7:0] data_xor(input int n);
    logic [7:0] x = '0;
    for (int i = 0; i < 4*n; i++) x ^= stim[i];
    return x;
  endfunction

  task automatic build_rand(input int n);
    stim.delete();
    for (int i = 0; i < 4*n; i++) stim.push_back(8'($urandom_range(0, 255)));
    if (CK == 1) stim.push_back(data_xor(n));
  endtask

  task automatic clear_obs();
    wa.delete(); wd.delete(); wab.delete(); wdb.delete();
    done_cnt = 0; rdy_cnt = 0; hold_bad = 0;
  endtask

  task automatic do_start(input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1; len = n; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    track = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int pre_gap, output bit ok);
    in_valid = 1'b0;
    repeat (pre_gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_byte = b; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 1'b0; lat = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; lat = cyc - t0; end
      @(posedge clk); #1;
    end
    track = 1'b0;
  endtask

  task automatic run_load(input int n, input int gap_at, input int gap_len, input bit rnd,
                          output int lat, output bit ok);
    bit a, d;
    int g;
    do_start(8'(n));
    ok = 1'b1;
    for (int k = 0; k < stim.size(); k++) begin
      g = (k == gap_at) ? gap_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      send_byte(stim[k], g, a);
      if (!a) ok = 1'b0;
    end
    wait_done(lat, d);
    if (!d) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, cpu_hold, done, mem_addr, mem_wdata, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {in_ready, mem_we, cpu_hold, done, mem_addr, mem_wdata, err});
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_priority: cpu_hold=%b required 0", cpu_hold);
    end
  endtask

  task automatic test_basic();
    logic [7:0] img[8] = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h00, 8'h61, 8'h18, 8'h22};
    logic [31:0] ew[2] = '{32'h00220820, 32'h00611822};
    int lat; bit ok;
    clear_obs();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(img[i]);
    if (CK == 1) stim.push_back(data_xor(2));
    run_load(2, -1, 0, 1'b0, lat, ok);
    checks++;
    if (!ok || wa.size() != 2) begin
      errors++;
      $display("FAIL basic_writes: ok=%0d writes=%0d required ok=1 writes=2", ok, wa.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wa[i] !== 8'(i) || wd[i] !== ew[i]) begin
          errors++;
          $display("FAIL basic_word%0d: got %h@%0d required %h@%0d", i, wd[i], wa[i], ew[i], i);
        end
      end
    end
    // Cycles from the start cycle to the done cycle inclusive are 1+5N+1 (+1 with checksum).
    checks++;
    if (lat !== (1 + 5*2 + 1) - 1 + CK) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, 5*2 + 1 + CK);
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL basic_hold: low cycles=%0d required 0", hold_bad);
    end
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== ew[1] || mem_addr !== 8'd1) begin
      errors++;
      $display("FAIL basic_idle_hold: hold=%b we=%b data=%h addr=%0d required 0 0 %h 1",
               cpu_hold, mem_we, mem_wdata, mem_addr, ew[1]);
    end
  endtask

  task automatic test_stall();
    int lat; bit ok;
    clear_obs();
    build_rand(1);
    run_load(1, 2, 3, 1'b0, lat, ok);
    checks++;
    if (!ok || wa.size() != 1 || wd[0] !== exp_word(0) || wa[0] !== 8'd0) begin
      errors++;
      $display("FAIL stall_write: ok=%0d writes=%0d required one write of %h", ok, wa.size(), exp_word(0));
    end
    checks++;
    if (lat !== 5 + 1 + CK + 3) begin
      errors++;
      $display("FAIL stall_latency: got %0d required %0d", lat, 5 + 1 + CK + 3);
    end
  endtask

  task automatic test_len0();
    int lat; bit ok;
    clear_obs();
    stim.delete();
    run_load(0, -1, 0, 1'b0, lat, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || lat !== 1) begin
      errors++;
      $display("FAIL len0_done: ok=%0d latency=%0d required ok=1 latency=1", ok, lat);
    end
    checks++;
    if (wa.size() != 0 || rdy_cnt != 0) begin
      errors++;
      $display("FAIL len0_quiet: writes=%0d ready_cycles=%0d required 0 0", wa.size(), rdy_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] eb[3] = '{8'd254, 8'd255, 8'd0};
    int lat; bit ok;
    clear_obs();
    build_rand(3);
    run_load(3, -1, 0, 1'b0, lat, ok);
    checks++;
    if (!ok || wab.size() != 3 || wa.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: ok=%0d writes=%0d/%0d required 3/3", ok, wa.size(), wab.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wab[i] !== eb[i] || wdb[i] !== exp_word(i) || wa[i] !== 8'(i)) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h@%0d required %h@%0d", i, wdb[i], wab[i], exp_word(i), eb[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit a;
    int lat; bit ok;
    clear_obs();
    build_rand(3);
    do_start(8'd3);
    for (int k = 0; k < 4; k++) send_byte(stim[k], 0, a);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_byte = stim[4];
    @(posedge clk); @(negedge clk);
    checks++;
    if ({in_ready, mem_we, cpu_hold, done, mem_addr, mem_wdata, err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %h required 0", {in_ready, mem_we, cpu_hold, done, mem_addr, mem_wdata, err});
    end
    @(posedge clk); #1;
    rst = 1'b0; track = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (wa.size() != 1 || wd[0] !== exp_word(0)) begin
      errors++;
      $display("FAIL abort_writes: writes=%0d required 1 of %h", wa.size(), exp_word(0));
    end
    clear_obs();
    build_rand(1);
    run_load(1, -1, 0, 1'b0, lat, ok);
    checks++;
    if (!ok || wa.size() != 1 || wd[0] !== exp_word(0) || wa[0] !== 8'd0) begin
      errors++;
      $display("FAIL abort_restart: ok=%0d writes=%0d required one write of %h@0", ok, wa.size(), exp_word(0));
    end
  endtask

  task automatic test_ignore_start();
    bit a, d;
    int lat;
    clear_obs();
    build_rand(2);
    do_start(8'd2);
    send_byte(stim[0], 0, a);
    send_byte(stim[1], 0, a);
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 2; k < stim.size(); k++) send_byte(stim[k], 0, a);
    wait_done(lat, d);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (!d || done_cnt != 1 || wa.size() != 2 || wd[0] !== exp_word(0) || wd[1] !== exp_word(1)) begin
      errors++;
      $display("FAIL ignore_start: done=%0d dones=%0d writes=%0d required 1 1 2", d, done_cnt, wa.size());
    end
    checks++;
    if (lat !== 5*2 + 1 + CK + 1) begin
      errors++;
      $display("FAIL ignore_latency: got %0d required %0d", lat, 5*2 + 1 + CK + 1);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] img[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    int lat; bit ok, a;
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(img[i]);
      stim.push_back(pass == 0 ? 8'h08 : 8'h09);
      run_load(1, -1, 0, 1'b0, lat, ok);
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (!ok || err !== 1'(pass) || wd.size() != 1 || wd[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL checksum_pass%0d: ok=%0d err=%b required err=%0d", pass, ok, err, pass);
      end
    end
    clear_obs();
    build_rand(1);
    do_start(8'd1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL checksum_clear: err=%b required 0", err);
    end
    @(posedge clk); #1;
    for (int k = 0; k < stim.size(); k++) send_byte(stim[k], 0, a);
    wait_done(lat, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL checksum_reload: ok=%0d err=%b required 1 0", ok, err);
    end
  endtask
`endif

  task automatic test_random();
    int lat, n; bit ok;
    for (int t = 0; t < 8; t++) begin
      clear_obs();
      n = $urandom_range(1, 6);
      build_rand(n);
      run_load(n, -1, 0, 1'b1, lat, ok);
      checks++;
      if (!ok || wa.size() != n || wab.size() != n || err !== 1'b0) begin
        errors++;
        $display("FAIL random%0d_count: ok=%0d writes=%0d/%0d err=%b required %0d", t, ok, wa.size(), wab.size(), err, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wa[i] !== exp_addr(0, i) || wd[i] !== exp_word(i) ||
              wab[i] !== exp_addr(254, i) || wdb[i] !== exp_word(i)) begin
            errors++;
            $display("FAIL random%0d_word%0d: got %h@%0d/%0d required %h@%0d/%0d", t, i, wd[i], wa[i], wab[i],
                     exp_word(i), exp_addr(0, i), exp_addr(254, i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_wrap();
    test_abort();
    test_ignore_start();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The parameter list SHALL be:
- ADDR_W, default 8, instruction-memory address width; matches the 8-bit PC.
- BASE_ADDR, default 0, word address of the first loaded instruction.

REQ-002 The port list SHALL be:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle load request, sampled only in IDLE.
- len  input  ADDR_W  number of 32-bit words to load, sampled with start.
- in_valid  input  1  byte-stream valid.
- in_byte  input  8  byte-stream data, most-significant byte of each word first.
- in_ready  output  1  byte-stream ready.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  instruction-memory word address.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  holds the pipeline's PC and IF/ID register while loading.
- done  output  1  one-cycle pulse at load completion.
- err  output  1  checksum mismatch; present only with LOADER_CHECKSUM_EN.

Function
REQ-003 The FSM SHALL have states IDLE, RECV, WRITE, CHECK (checksum build only) and DONE.
REQ-004 In IDLE, start=1 with len>0 SHALL latch len, clear the byte and word counters, and enter RECV on the next cycle.
REQ-005 In IDLE, start=1 with len=0 SHALL enter DONE directly and issue no memory write.
REQ-006 in_ready SHALL be 1 only in RECV; a byte is accepted on any cycle where in_valid and in_ready are both 1.
REQ-007 Accepted bytes SHALL be shifted into a 32-bit word MSB-first; a cycle with in_valid=0 SHALL not advance the byte counter.
REQ-008 On acceptance of the 4th byte of a word, the FSM SHALL enter WRITE for exactly one cycle.
REQ-009 In WRITE, the block SHALL assert mem_we=1, mem_addr=(BASE_ADDR+word_index) mod 2^ADDR_W, and mem_wdata=the assembled word.
REQ-010 After WRITE, the word index SHALL increment; the FSM SHALL return to RECV if words remain, otherwise go to CHECK (if compiled in) or DONE.
REQ-011 Address wrap-around past 2^ADDR_W-1 SHALL continue at 0 without error.
REQ-012 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-013 cpu_hold SHALL be 1 in every state except IDLE.
REQ-014 Outside WRITE, mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold their last written values.
REQ-015 start asserted in any state other than IDLE SHALL be ignored.
REQ-016 Minimum load latency for N words SHALL be 1 + 5N + 1 cycles from start to done, plus 1 cycle with checksum enabled.

Reset
REQ-017 A synchronous rst SHALL force IDLE and set in_ready, mem_we, cpu_hold, done and err to 0, and clear mem_addr, mem_wdata and all counters.
REQ-018 rst asserted mid-load SHALL abort the load immediately with no further writes; words already written SHALL remain in memory.
REQ-019 rst SHALL take priority over start on the same cycle.

Configuration
REQ-020 With LOADER_CHECKSUM_EN defined:
- After the last WRITE, the FSM SHALL enter CHECK and accept one further byte.
- err SHALL be set to (byte != XOR of all data bytes).
- The FSM SHALL then go to DONE.
- err SHALL hold until the next accepted start or rst.
REQ-021 Without LOADER_CHECKSUM_EN, the CHECK state, the err port and the XOR accumulator SHALL be absent.

Structure
REQ-022 A shared package loader_pkg SHALL hold the FSM state enumeration and the BYTES_PER_WORD=4 constant.
REQ-023 Byte packing SHALL be a sub-module imem_word_assembler containing:
- the shift register;
- a 2-bit byte counter;
- a word_ready pulse;
- a clear input.
REQ-024 The top level SHALL contain only the FSM, the word counter and the checksum logic.

Verification
REQ-025 start, len=2, bytes 00 22 08 20 00 61 18 22 streamed back-to-back -> writes 0x00220820 @0 and 0x00611822 @1, then done one cycle after the 2nd write; cpu_hold high from the cycle after start through DONE.
REQ-026 start, len=1, in_valid deasserted for 3 cycles between byte 2 and byte 3 -> exactly one write of the correct word, with latency extended by 3 cycles.
REQ-027 start, len=0 -> no mem_we, done on the next cycle, in_ready never asserted.
REQ-028 BASE_ADDR=254, len=3 -> writes at addresses 254, 255, 0.
REQ-029 rst asserted after the first write of a len=3 load -> no further writes, all outputs at 0 in the next cycle; a new start then succeeds.
REQ-030 LOADER_CHECKSUM_EN, len=1, bytes 12 34 56 78 then checksum 08 -> err=0; same stimulus with checksum 09 -> err=1; second start during RECV -> ignored.
